// File: rtl/trace_check_pkg.sv
// trace_check_pkg: state encoding, output codes and character constants shared by trace_line_checker.
package trace_check_pkg;

   typedef enum logic [3:0] {
      S_IDLE, S_TIME, S_PC, S_COLON, S_SP1, S_REG, S_ADDR,
      S_SP2, S_LT, S_EQ, S_SP3, S_DATA, S_DONE
   } state_t;

   localparam logic [1:0] FMT_NONE = 2'd0;
   localparam logic [1:0] FMT_REG  = 2'd1;
   localparam logic [1:0] FMT_MEM  = 2'd2;

   localparam int ERR_TIME = 0;
   localparam int ERR_PC   = 1;
   localparam int ERR_ADDR = 2;
   localparam int ERR_REG  = 3;

   localparam logic [7:0] CH_CARET  = 8'h5E;
   localparam logic [7:0] CH_AT     = 8'h40;
   localparam logic [7:0] CH_COLON  = 8'h3A;
   localparam logic [7:0] CH_SPACE  = 8'h20;
   localparam logic [7:0] CH_DOLLAR = 8'h24;
   localparam logic [7:0] CH_STAR   = 8'h2A;
   localparam logic [7:0] CH_LT     = 8'h3C;
   localparam logic [7:0] CH_EQ     = 8'h3D;
   localparam logic [7:0] CH_HASH   = 8'h23;

   // Bits needed to hold any decimal number of the given digit count without truncation.
   function automatic int dec_width(input int digits);
      longint m = 1;
      for (int i = 0; i < digits; i++) m = m * 10;
      return $clog2(m);
   endfunction

endpackage

// File: rtl/char_class.sv
// char_class: classifies an ASCII character as decimal / lowercase hex digit and yields its value.
module char_class (
   input  logic [7:0] char,
   output logic       is_dec,
   output logic       is_hex,
   output logic [3:0] nibble
);
   logic is_af;
   always_comb begin
      is_dec = char >= 8'h30 && char <= 8'h39;
      is_af  = char >= 8'h61 && char <= 8'h66;
      is_hex = is_dec || is_af;
      nibble = is_af ? 4'(char - 8'h57) : char[3:0];
   end
endmodule

// File: rtl/trace_line_checker.sv
// trace_line_checker: parses one trace character per cycle and reports each complete line's
// format and field errors for exactly one cycle.
module trace_line_checker
   import trace_check_pkg::*;
#(
   parameter int          TIME_DIGITS = 4,
   parameter int          REG_DIGITS  = 4,
   parameter logic [31:0] PC_LO       = 32'h0000_3000,
   parameter logic [31:0] PC_HI       = 32'h0000_6FFC,
   parameter logic [31:0] ADDR_HI     = 32'h0000_2FFC,
   parameter int          FREQ_W      = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [7:0]        char,
   input  logic [FREQ_W-1:0] freq,
   output logic [1:0]        format_type,
   output logic [3:0]        error_code
);
   localparam int TW   = dec_width(TIME_DIGITS);
   localparam int RW   = dec_width(REG_DIGITS);
   localparam int MAXD = TIME_DIGITS > REG_DIGITS ? (TIME_DIGITS > 8 ? TIME_DIGITS : 8)
                                                  : (REG_DIGITS > 8 ? REG_DIGITS : 8);
   localparam int CW   = $clog2(MAXD + 1);
   localparam int MW   = TW > FREQ_W ? TW : FREQ_W;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [TW-1:0]   time_q, time_d;
   logic [31:0]     pc_q, pc_d;
   logic [RW-1:0]   reg_q, reg_d;
   logic [31:0]     addr_q, addr_d;
   logic            mem_q, mem_d;

   logic            is_dec, is_hex;
   logic [3:0]      nibble;
   logic            is_sp;
   logic            cnt_full;
   logic [FREQ_W-1:0] half_m1;
   logic [3:0]      err;

   char_class u_class (
      .char  (char),
      .is_dec(is_dec),
      .is_hex(is_hex),
      .nibble(nibble)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         time_q  <= '0;
         pc_q    <= '0;
         reg_q   <= '0;
         addr_q  <= '0;
         mem_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         time_q  <= time_d;
         pc_q    <= pc_d;
         reg_q   <= reg_d;
         addr_q  <= addr_d;
         mem_q   <= mem_d;
      end
   end

   // cnt_q counts digits of whichever field is currently being collected.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      time_d   = time_q;
      pc_d     = pc_q;
      reg_d    = reg_q;
      addr_d   = addr_q;
      mem_d    = mem_q;
      is_sp    = char == CH_SPACE;
      cnt_full = cnt_q == CW'(8);
      if (char == CH_CARET) begin
         state_d = S_TIME;
         cnt_d   = '0;
         time_d  = '0;
         pc_d    = '0;
         reg_d   = '0;
         addr_d  = '0;
         mem_d   = 1'b0;
      end else begin
         case (state_q)
            S_TIME:
               if (is_dec && int'(cnt_q) < TIME_DIGITS) begin
                  time_d = time_q * TW'(10) + TW'(nibble);
                  cnt_d  = cnt_q + CW'(1);
               end else if (char == CH_AT && cnt_q != '0) begin
                  state_d = S_PC;
                  cnt_d   = '0;
               end else state_d = S_IDLE;
            S_PC:
               if (is_hex && !cnt_full) begin
                  pc_d  = {pc_q[27:0], nibble};
                  cnt_d = cnt_q + CW'(1);
               end else state_d = char == CH_COLON && cnt_full ? S_COLON : S_IDLE;
            S_COLON, S_SP1: begin
               cnt_d   = '0;
               mem_d   = char == CH_STAR;
               state_d = is_sp ? S_SP1 : char == CH_DOLLAR ? S_REG : char == CH_STAR ? S_ADDR : S_IDLE;
            end
            S_REG:
               if (is_dec && int'(cnt_q) < REG_DIGITS) begin
                  reg_d = reg_q * RW'(10) + RW'(nibble);
                  cnt_d = cnt_q + CW'(1);
               end else if (cnt_q != '0) state_d = is_sp ? S_SP2 : char == CH_LT ? S_LT : S_IDLE;
               else state_d = S_IDLE;
            S_ADDR:
               if (is_hex && !cnt_full) begin
                  addr_d = {addr_q[27:0], nibble};
                  cnt_d  = cnt_q + CW'(1);
               end else if (cnt_full) state_d = is_sp ? S_SP2 : char == CH_LT ? S_LT : S_IDLE;
               else state_d = S_IDLE;
            S_SP2:
               state_d = is_sp ? S_SP2 : char == CH_LT ? S_LT : S_IDLE;
            S_LT:
               state_d = char == CH_EQ ? S_EQ : S_IDLE;
            S_EQ, S_SP3: begin
               cnt_d   = CW'(1);
               state_d = is_sp ? S_SP3 : is_hex ? S_DATA : S_IDLE;
            end
            S_DATA:
               if (is_hex && !cnt_full) cnt_d = cnt_q + CW'(1);
               else state_d = char == CH_HASH && cnt_full ? S_DONE : S_IDLE;
            default:
               state_d = S_IDLE;
         endcase
      end
   end

   always_comb begin
      half_m1        = (freq >> 1) - FREQ_W'(1);
      err            = '0;
      err[ERR_TIME]  = |(MW'(time_q) & MW'(half_m1));
      err[ERR_PC]    = pc_q[1:0] != 2'b00 || pc_q < PC_LO || pc_q > PC_HI;
      err[ERR_ADDR]  = mem_q && (addr_q[1:0] != 2'b00 || addr_q > ADDR_HI);
      err[ERR_REG]   = !mem_q && 64'(reg_q) > 64'd31;
      format_type    = state_q == S_DONE ? (mem_q ? FMT_MEM : FMT_REG) : FMT_NONE;
      error_code     = state_q == S_DONE ? err : 4'b0000;
   end

endmodule

// File: tb/tb_trace_line_checker.sv
// tb_trace_line_checker: drives directed and random trace lines and compares every cycle
// against a string-level grammar model of the line format.
module tb_trace_line_checker;
   localparam int TD = 4;
   localparam int RD = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [7:0]  char = 8'h00;
   logic [15:0] freq = 16'd4;
   logic [1:0]  format_type;
   logic [3:0]  error_code;

   int          checks = 0;
   int          errors = 0;
   string       line_buf = "";
   logic [1:0]  last_ft;
   logic [3:0]  last_ec;

   trace_line_checker dut (
      .clk        (clk),
      .reset      (reset),
      .char       (char),
      .freq       (freq),
      .format_type(format_type),
      .error_code (error_code)
   );

   always #5 clk = ~clk;

   function automatic bit is_dec(input logic [7:0] c);
      return c >= "0" && c <= "9";
   endfunction

   function automatic bit is_hex(input logic [7:0] c);
      return is_dec(c) || (c >= "a" && c <= "f");
   endfunction

   function automatic int hexv(input logic [7:0] c);
      return is_dec(c) ? int'(c) - 48 : int'(c) - 87;
   endfunction

   function automatic int read_num(input string s, inout int i, input bit hex, output longint v);
      int n = 0;
      v = 0;
      while (i < s.len() && n < 20 && (hex ? is_hex(s[i]) : is_dec(s[i]))) begin
         v = hex ? v * 16 + longint'(hexv(s[i])) : v * 10 + longint'(hexv(s[i]));
         n++;
         i++;
      end
      return n;
   endfunction

   function automatic void skip_sp(input string s, inout int i);
      while (i < s.len() && s[i] == " ") i++;
   endfunction

   function automatic bit eat(input string s, inout int i, input logic [7:0] c);
      if (i < s.len() && s[i] == c) begin
         i++;
         return 1'b1;
      end
      return 1'b0;
   endfunction

   // Whole-line grammar check; kind is 1 for a register write, 2 for a memory write.
   function automatic bit parse(input string s, output int kind, output longint t,
                                output longint pc, output longint r, output longint a);
      int i = 1;
      int n;
      longint d;
      kind = 0; t = 0; pc = 0; r = 0; a = 0;
      if (s.len() == 0 || s[0] != "^") return 1'b0;
      n = read_num(s, i, 1'b0, t);
      if (n < 1 || n > TD) return 1'b0;
      if (!eat(s, i, "@")) return 1'b0;
      if (read_num(s, i, 1'b1, pc) != 8) return 1'b0;
      if (!eat(s, i, ":")) return 1'b0;
      skip_sp(s, i);
      if (eat(s, i, "$")) begin
         kind = 1;
         n = read_num(s, i, 1'b0, r);
         if (n < 1 || n > RD) return 1'b0;
      end else if (eat(s, i, "*")) begin
         kind = 2;
         if (read_num(s, i, 1'b1, a) != 8) return 1'b0;
      end else return 1'b0;
      skip_sp(s, i);
      if (!eat(s, i, "<")) return 1'b0;
      if (!eat(s, i, "=")) return 1'b0;
      skip_sp(s, i);
      if (read_num(s, i, 1'b1, d) != 8) return 1'b0;
      if (!eat(s, i, "#")) return 1'b0;
      return i == s.len();
   endfunction

   function automatic void model_line(input string s, input int f, output logic [1:0] ft,
                                      output logic [3:0] ec);
      int kind;
      longint t, pc, r, a;
      ft = 2'd0;
      ec = 4'd0;
      if (parse(s, kind, t, pc, r, a)) begin
         ft    = 2'(kind);
         ec[0] = (t % longint'(f / 2)) != 0;
         ec[1] = (pc % 4) != 0 || pc < 64'h3000 || pc > 64'h6ffc;
         ec[2] = kind == 2 && ((a % 4) != 0 || a > 64'h2ffc);
         ec[3] = kind == 1 && r > 31;
      end
   endfunction

   task automatic send_char(input logic [7:0] c, input string tag);
      logic [1:0] eft;
      logic [3:0] eec;
      eft = 2'd0;
      eec = 4'd0;
      if (c == "^") line_buf = "^";
      else if (line_buf.len() > 0) line_buf = {line_buf, $sformatf("%c", c)};
      if (c == "#" && line_buf.len() > 0) begin
         model_line(line_buf, int'(freq), eft, eec);
         line_buf = "";
      end
      char = c;
      @(posedge clk);
      #1;
      checks++;
      if (format_type !== eft || error_code !== eec) begin
         errors++;
         $display("FAIL %s after '%c': format_type=%0d error_code=%b, expected %0d %b",
                  tag, c, format_type, error_code, eft, eec);
      end
      last_ft = format_type;
      last_ec = error_code;
   endtask

   task automatic send_str(input string s, input string tag);
      for (int i = 0; i < s.len(); i++) send_char(s[i], tag);
   endtask

   task automatic do_reset(input logic [7:0] c, input string tag);
      reset = 1'b1;
      char  = c;
      @(posedge clk);
      #1;
      reset    = 1'b0;
      line_buf = "";
      checks++;
      if (format_type !== 2'd0 || error_code !== 4'd0) begin
         errors++;
         $display("FAIL %s reset: format_type=%0d error_code=%b, expected 0 0000",
                  tag, format_type, error_code);
      end
   endtask

   task automatic test_reset();
      do_reset(8'h00, "reset_plain");
      do_reset("^", "reset_caret");
      freq = 16'd4;
      send_str("12@00003000: $1 <= 00000000#", "reset_caret_tail");
      checks++;
      if (last_ft !== 2'd0) begin
         errors++;
         $display("FAIL reset_caret_priority: format_type=%0d, expected 0", last_ft);
      end
   endtask

   task automatic test_directed();
      string      dv[6];
      int         df[6];
      logic [1:0] dft[6];
      logic [3:0] dec_[6];
      dv   = '{"^338@00003130: *00000088 <= fffb528#",
               "^10@00003000: $5 <= 0000abcd#",
               "^11@00003002: *00003000 <= 00000001#",
               "^8@00003004: $32 <= 00000000#",
               "^12345@00003000: $1 <= 00000000#",
               "^1^2@00003000: $1 <= 00000000#"};
      df   = '{4, 4, 4, 16, 4, 4};
      dft  = '{2'd0, 2'd1, 2'd2, 2'd1, 2'd0, 2'd1};
      dec_ = '{4'b0000, 4'b0000, 4'b0111, 4'b1000, 4'b0000, 4'b0000};
      for (int k = 0; k < 6; k++) begin
         freq = 16'(df[k]);
         send_str(dv[k], $sformatf("directed%0d", k));
         checks++;
         if (last_ft !== dft[k] || last_ec !== dec_[k]) begin
            errors++;
            $display("FAIL directed%0d final: format_type=%0d error_code=%b, expected %0d %b",
                     k, last_ft, last_ec, dft[k], dec_[k]);
         end
      end
   endtask

   task automatic test_reset_midline();
      freq = 16'd4;
      send_str("^12@0000", "midline_head");
      do_reset(8'h00, "midline");
      send_str("3000: $1 <= 00000000#", "midline_tail");
      checks++;
      if (last_ft !== 2'd0) begin
         errors++;
         $display("FAIL midline_discard: format_type=%0d, expected 0", last_ft);
      end
      send_str("^12@00003000: $1 <= 00000000#", "midline_after");
      checks++;
      if (last_ft !== 2'd1 || last_ec !== 4'b0000) begin
         errors++;
         $display("FAIL midline_recover: format_type=%0d error_code=%b, expected 1 0000",
                  last_ft, last_ec);
      end
   endtask

   task automatic test_reset_priority();
      freq = 16'd4;
      send_str("^10@00003000: $5 <= 0000abcd", "prio_head");
      do_reset("#", "prio_hash");
      send_char(" ", "prio_after");
      checks++;
      if (last_ft !== 2'd0) begin
         errors++;
         $display("FAIL prio_hash_line: format_type=%0d, expected 0", last_ft);
      end
   endtask

   task automatic test_back_to_back();
      freq = 16'd8;
      send_str("^4@00003ffc: *00002ffc <= deadbeef#", "b2b_first");
      checks++;
      if (last_ft !== 2'd2 || last_ec !== 4'b0000) begin
         errors++;
         $display("FAIL b2b_first: format_type=%0d error_code=%b, expected 2 0000", last_ft, last_ec);
      end
      send_str("^7@00007000: $31 <= 00000000#", "b2b_second");
      checks++;
      if (last_ft !== 2'd1 || last_ec !== 4'b0011) begin
         errors++;
         $display("FAIL b2b_second: format_type=%0d error_code=%b, expected 1 0011", last_ft, last_ec);
      end
   endtask

   function automatic string digits(input int n);
      string s = "";
      for (int i = 0; i < n; i++) s = {s, $sformatf("%0d", $urandom_range(0, 9))};
      return s;
   endfunction

   function automatic string spaces();
      string s = "";
      int n = $urandom_range(0, 2);
      for (int i = 0; i < n; i++) s = {s, " "};
      return s;
   endfunction

   function automatic logic [31:0] pick_pc();
      logic [31:0] bnd[4];
      bnd = '{32'h2ffc, 32'h3000, 32'h6ffc, 32'h7000};
      case ($urandom_range(0, 3))
         0:       return 32'h3000 + 32'($urandom_range(0, 32'h0fff)) * 4;
         1:       return 32'($urandom);
         2:       return 32'h3000 + 32'($urandom_range(0, 32'h3fff));
         default: return bnd[$urandom_range(0, 3)];
      endcase
   endfunction

   function automatic logic [31:0] pick_addr();
      case ($urandom_range(0, 3))
         0:       return 32'($urandom_range(0, 32'h0bff)) * 4;
         1:       return 32'h2ffc;
         2:       return 32'h3000;
         default: return 32'($urandom);
      endcase
   endfunction

   function automatic string gen_line();
      string s;
      string junk = "0123456789abcdefA@:$*<=# ^xZ";
      string c;
      int pos;
      int nt = $urandom_range(0, 9) == 0 ? TD + 1 : $urandom_range(1, TD);
      s = {"^", digits(nt), "@", $sformatf("%08h", pick_pc()), ":", spaces()};
      if ($urandom_range(0, 1) == 1)
         s = {s, "$", digits($urandom_range(0, 9) == 0 ? RD + 1 : $urandom_range(1, RD))};
      else
         s = {s, "*", $sformatf("%08h", pick_addr())};
      s = {s, spaces(), "<=", spaces(), $sformatf("%08h", $urandom), "#"};
      if ($urandom_range(0, 3) == 0) begin
         pos = $urandom_range(1, s.len() - 1);
         c   = junk.substr($urandom_range(0, junk.len() - 1), 0);
         c   = c.substr(0, 0);
         if ($urandom_range(0, 1) == 1)
            s = {s.substr(0, pos - 1), c, s.substr(pos + 1, s.len() - 1)};
         else
            s = {s.substr(0, pos - 1), c, s.substr(pos, s.len() - 1)};
      end
      return s;
   endfunction

   task automatic test_random();
      string s;
      int cut;
      for (int k = 0; k < 150; k++) begin
         freq = 16'(1 << $urandom_range(1, 5));
         s = gen_line();
         if ($urandom_range(0, 19) == 0) begin
            cut = $urandom_range(1, s.len() - 1);
            send_str(s.substr(0, cut - 1), "rand_head");
            do_reset(8'($urandom_range(32, 126)), "rand_reset");
            send_str(s.substr(cut, s.len() - 1), "rand_tail");
         end else begin
            send_str(s, "rand_line");
         end
         for (int g = $urandom_range(0, 2); g > 0; g--)
            send_char(8'($urandom_range(32, 126)), "rand_gap");
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_reset_midline();
      test_reset_priority();
      test_back_to_back();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
